clock_controller: RTL and testbench

- Timekeeping controller for the 24-hour seconds/minutes/hours clock datapath.
- Generates the one-second tick from the system clock using a prescaler.
- Sequences run and set modes from two pushbutton inputs, and owns the hh:mm:ss registers with carry and wrap.
- Raises a sticky alarm on a programmed hh:mm match; sits between board buttons and the display/driver logic.

---
 rtl/clock_controller_if.sv | 22 ++
 rtl/clock_controller.sv | 79 +++++++
 tb/tb_clock_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_controller_if.sv
// clock_controller_if: pushbutton, alarm-setting and time-display signals of the clock controller
interface clock_controller_if;
  logic       mode_btn;
  logic       inc_btn;
  logic       alarm_en;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       tick;
  logic [6:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [1:0] mode;
  logic       alarm;
  modport master (
    output mode_btn, inc_btn, alarm_en, alarm_hr, alarm_min,
    input  tick, seconds, minutes, hours, mode, alarm
  );
  modport slave (
    input  mode_btn, inc_btn, alarm_en, alarm_hr, alarm_min,
    output tick, seconds, minutes, hours, mode, alarm
  );
endinterface

// File: rtl/clock_controller.sv
// clock_controller: one-second prescaler, run/set mode sequencing, hh:mm:ss registers and sticky alarm
module clock_controller #(
  parameter int TICK_DIV = 4,
  parameter int PRE_W    = 8
) (
  input logic           clk,
  input logic           reset,
  clock_controller_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} mode_t;
  mode_t            mode_q, mode_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [6:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hr_q, hr_d;
  logic             alarm_q, alarm_d;
  logic             mode_btn_q, inc_btn_q;
  logic             mode_e, inc_e, tick, sec_wrap, min_wrap, hr_wrap, match;
  // A mode edge wins over a coincident increment edge, so inc_e is masked here once for all users.
  assign mode_e   = bus.mode_btn & ~mode_btn_q;
  assign inc_e    = bus.inc_btn & ~inc_btn_q & ~mode_e;
  assign tick     = (mode_q == RUN) && (pre_q == PRE_W'(TICK_DIV - 1));
  assign sec_wrap = sec_q == 7'd59;
  assign min_wrap = min_q == 6'd59;
  assign hr_wrap  = hr_q == 5'd23;
  // Mode sequencing and prescaler; the prescaler only counts while staying in RUN so re-entry starts at 0.
  always_comb begin
    mode_d = !mode_e ? mode_q :
             mode_q == RUN     ? SET_HR  :
             mode_q == SET_HR  ? SET_MIN :
             mode_q == SET_MIN ? SET_SEC : RUN;
    pre_d  = (mode_q == RUN && mode_d == RUN && !tick) ? pre_q + PRE_W'(1) : '0;
  end
  // Time update: ticks carry through all fields, manual edits touch only the field being set.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (tick) begin
      sec_d = sec_wrap ? '0 : sec_q + 7'd1;
      min_d = !sec_wrap ? min_q : min_wrap ? '0 : min_q + 6'd1;
      hr_d  = !(sec_wrap && min_wrap) ? hr_q : hr_wrap ? '0 : hr_q + 5'd1;
    end else if (inc_e) begin
      hr_d  = mode_q != SET_HR ? hr_q : hr_wrap ? '0 : hr_q + 5'd1;
      min_d = mode_q != SET_MIN ? min_q : min_wrap ? '0 : min_q + 6'd1;
      sec_d = mode_q == SET_SEC ? '0 : sec_q;
    end
    match   = bus.alarm_en && hr_d == bus.alarm_hr && min_d == bus.alarm_min && sec_d == 7'd0;
    alarm_d = (!bus.alarm_en || (inc_e && mode_q == RUN)) ? 1'b0 : (tick && match) ? 1'b1 : alarm_q;
  end
  // State registers, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= RUN;
      pre_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      alarm_q    <= 1'b0;
      mode_btn_q <= 1'b0;
      inc_btn_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      pre_q      <= pre_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      alarm_q    <= alarm_d;
      mode_btn_q <= bus.mode_btn;
      inc_btn_q  <= bus.inc_btn;
    end
  end
  assign bus.tick    = tick;
  assign bus.seconds = sec_q;
  assign bus.minutes = min_q;
  assign bus.hours   = hr_q;
  assign bus.mode    = mode_q;
  assign bus.alarm   = alarm_q;
endmodule

// File: tb/tb_clock_controller.sv
// tb_clock_controller: randomized and directed checks of clock_controller against a seconds-of-day model
module tb_clock_controller;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  clock_controller_if b();
  clock_controller #(.TICK_DIV(TD), .PRE_W(8)) dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  int nchk = 0;
  int nfail = 0;
  int t_m, md_m, pre_m;
  bit alm_m, mbp, ibp;
  function automatic void model_reset();
    t_m = 0; md_m = 0; pre_m = 0; alm_m = 0; mbp = 0; ibp = 0;
  endfunction
  function automatic void model_edge();
    bit me, ie, tk;
    int h, m, s;
    me = b.mode_btn && !mbp;
    ie = b.inc_btn && !ibp && !me;
    tk = md_m == 0 && pre_m == TD - 1;
    h = t_m / 3600; m = (t_m / 60) % 60; s = t_m % 60;
    if (tk) t_m = (t_m + 1) % 86400;
    else if (ie && md_m == 1) t_m = ((h + 1) % 24) * 3600 + m * 60 + s;
    else if (ie && md_m == 2) t_m = h * 3600 + ((m + 1) % 60) * 60 + s;
    else if (ie && md_m == 3) t_m = t_m - s;
    if (!b.alarm_en || (ie && md_m == 0)) alm_m = 0;
    else if (tk && int'(b.alarm_hr) < 24 && int'(b.alarm_min) < 60 &&
             t_m == int'(b.alarm_hr) * 3600 + int'(b.alarm_min) * 60) alm_m = 1;
    pre_m = (md_m == 0 && !me && !tk) ? pre_m + 1 : 0;
    md_m = me ? (md_m + 1) % 4 : md_m;
    mbp = b.mode_btn; ibp = b.inc_btn;
  endfunction
  function automatic logic [21:0] exp_state();
    return {md_m == 0 && pre_m == TD - 1, 7'(t_m % 60), 6'((t_m / 60) % 60), 5'(t_m / 3600), 2'(md_m), alm_m};
  endfunction
  function automatic logic [21:0] obs_state();
    return {b.tick, b.seconds, b.minutes, b.hours, b.mode, b.alarm};
  endfunction
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask
  task automatic press(input bit m, input bit i);
    b.mode_btn = m; b.inc_btn = i;
    step();
    b.mode_btn = 0; b.inc_btn = 0;
    step();
  endtask
  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 4 * TD && !(md_m == 0 && pre_m == TD - 1); c++) step();
      step();
    end
  endtask
  task automatic set_time(input int h, input int m, input int s);
    press(1, 0);
    repeat ((h - t_m / 3600 + 24) % 24) press(0, 1);
    press(1, 0);
    repeat ((m - (t_m / 60) % 60 + 60) % 60) press(0, 1);
    press(1, 0);
    press(0, 1);
    press(1, 0);
    for (int k = 0; k < 70 * TD && t_m % 60 != s; k++) step();
  endtask
  task automatic test_reset();
    b.mode_btn = 0; b.inc_btn = 0; b.alarm_en = 0; b.alarm_hr = 0; b.alarm_min = 0;
    #2 reset = 0;
    model_reset();
    repeat (10) begin
      @(negedge clk);
      nchk++;
      if (obs_state() !== 22'd0) begin nfail++; $display("FAIL reset_hold: got %h want 0", obs_state()); end
    end
    reset = 1;
    for (int i = 1; i <= 12; i++) begin
      step();
      nchk++;
      if (obs_state() !== exp_state()) begin nfail++; $display("FAIL reset_release c%0d: got %h want %h", i, obs_state(), exp_state()); end
      if (i % 4 == 0) begin
        nchk++;
        if (b.seconds !== 7'(i / 4)) begin nfail++; $display("FAIL reset_seconds c%0d: got %0d want %0d", i, b.seconds, i / 4); end
      end
    end
  endtask
  task automatic test_rollover();
    set_time(0, 0, 58);
    nchk++;
    if (obs_state() !== exp_state()) begin nfail++; $display("FAIL set_00_00_58: got %h want %h", obs_state(), exp_state()); end
    run_ticks(1);
    nchk++;
    if ({b.hours, b.minutes, b.seconds} !== {5'd0, 6'd0, 7'd59}) begin nfail++; $display("FAIL roll_59: got %0d:%0d:%0d want 0:0:59", b.hours, b.minutes, b.seconds); end
    run_ticks(1);
    nchk++;
    if ({b.hours, b.minutes, b.seconds} !== {5'd0, 6'd1, 7'd0}) begin nfail++; $display("FAIL roll_min: got %0d:%0d:%0d want 0:1:0", b.hours, b.minutes, b.seconds); end
    set_time(23, 59, 59);
    for (int k = 0; k < 4 * TD && t_m != 0; k++) begin
      step();
      nchk++;
      if (obs_state() !== exp_state()) begin nfail++; $display("FAIL roll_day_cycle: got %h want %h", obs_state(), exp_state()); end
    end
    nchk++;
    if ({b.hours, b.minutes, b.seconds} !== {5'd0, 6'd0, 7'd0}) begin nfail++; $display("FAIL roll_day: got %0d:%0d:%0d want 0:0:0", b.hours, b.minutes, b.seconds); end
  endtask
  task automatic test_set();
    int h0, m0, s0;
    press(1, 0);
    h0 = t_m / 3600; m0 = (t_m / 60) % 60; s0 = t_m % 60;
    for (int i = 0; i < 25; i++) begin
      press(0, 1);
      nchk++;
      if (b.tick !== 1'b0) begin nfail++; $display("FAIL set_tick: got %b want 0", b.tick); end
    end
    nchk++;
    if ({b.mode, b.hours, b.minutes, b.seconds} !== {2'd1, 5'((h0 + 25) % 24), 6'(m0), 7'(s0)})
      begin nfail++; $display("FAIL set_hours: got m%0d %0d:%0d:%0d want m1 %0d:%0d:%0d", b.mode, b.hours, b.minutes, b.seconds, (h0 + 25) % 24, m0, s0); end
    nchk++;
    if (obs_state() !== exp_state()) begin nfail++; $display("FAIL set_state: got %h want %h", obs_state(), exp_state()); end
  endtask
  task automatic test_simultaneous();
    int m0, n;
    press(1, 0);
    m0 = (t_m / 60) % 60;
    press(1, 1);
    nchk++;
    if ({b.mode, b.minutes} !== {2'd3, 6'(m0)}) begin nfail++; $display("FAIL simul: got m%0d min%0d want m3 min%0d", b.mode, b.minutes, m0); end
    press(0, 1);
    nchk++;
    if (b.seconds !== 7'd0) begin nfail++; $display("FAIL set_sec_clear: got %0d want 0", b.seconds); end
    b.mode_btn = 1;
    step();
    b.mode_btn = 0;
    n = 1;
    while (!b.tick && n < 3 * TD) begin step(); n++; end
    nchk++;
    if (n !== TD) begin nfail++; $display("FAIL run_first_tick: got %0d cycles want %0d", n, TD); end
    nchk++;
    if (obs_state() !== exp_state()) begin nfail++; $display("FAIL run_state: got %h want %h", obs_state(), exp_state()); end
  endtask
  task automatic test_alarm();
    b.alarm_en = 1; b.alarm_hr = 5'd7; b.alarm_min = 6'd30;
    set_time(7, 29, 59);
    nchk++;
    if (b.alarm !== 1'b0) begin nfail++; $display("FAIL alarm_pre: got %b want 0", b.alarm); end
    run_ticks(1);
    nchk++;
    if ({b.alarm, b.hours, b.minutes, b.seconds} !== {1'b1, 5'd7, 6'd30, 7'd0}) begin nfail++; $display("FAIL alarm_hit: got a%b %0d:%0d:%0d want a1 7:30:0", b.alarm, b.hours, b.minutes, b.seconds); end
    run_ticks(2);
    nchk++;
    if (b.alarm !== 1'b1) begin nfail++; $display("FAIL alarm_sticky: got %b want 1", b.alarm); end
    press(0, 1);
    nchk++;
    if (b.alarm !== 1'b0) begin nfail++; $display("FAIL alarm_clear: got %b want 0", b.alarm); end
    set_time(7, 29, 59);
    b.alarm_en = 0;
    run_ticks(1);
    nchk++;
    if (b.alarm !== 1'b0 || obs_state() !== exp_state()) begin nfail++; $display("FAIL alarm_disabled: got %h want %h", obs_state(), exp_state()); end
    b.alarm_en = 1; b.alarm_min = 6'd60;
    set_time(7, 59, 59);
    run_ticks(1);
    nchk++;
    if (b.alarm !== 1'b0 || obs_state() !== exp_state()) begin nfail++; $display("FAIL alarm_bad_min: got %h want %h", obs_state(), exp_state()); end
    b.alarm_en = 0;
  endtask
  task automatic test_async_reset();
    int n;
    set_time(12, 34, 56);
    for (int k = 0; k < 2 * TD && pre_m != 2; k++) step();
    nchk++;
    if (obs_state() !== exp_state()) begin nfail++; $display("FAIL pre_reset: got %h want %h", obs_state(), exp_state()); end
    #2 reset = 0;
    #1;
    nchk++;
    if (obs_state() !== 22'd0) begin nfail++; $display("FAIL async_reset: got %h want 0", obs_state()); end
    model_reset();
    @(negedge clk);
    reset = 1;
    n = 1;
    while (!b.tick && n < 3 * TD) begin step(); n++; end
    nchk++;
    if (n !== TD) begin nfail++; $display("FAIL reset_first_tick: got %0d cycles want %0d", n, TD); end
  endtask
  task automatic test_random();
    b.alarm_en = 1;
    b.alarm_hr = 5'(t_m / 3600);
    b.alarm_min = 6'(((t_m / 60) % 60 + 1) % 60);
    for (int i = 0; i < 800; i++) begin
      b.mode_btn = $urandom_range(0, 11) == 0;
      b.inc_btn = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 99) == 0) b.alarm_en = ~b.alarm_en;
      if ($urandom_range(0, 199) == 0) begin b.alarm_hr = 5'($urandom_range(0, 31)); b.alarm_min = 6'($urandom_range(0, 63)); end
      step();
      nchk++;
      if (obs_state() !== exp_state()) begin nfail++; $display("FAIL random c%0d: got %h want %h", i, obs_state(), exp_state()); end
    end
    b.mode_btn = 0; b.inc_btn = 0;
  endtask
  initial begin
    test_reset();
    test_rollover();
    test_set();
    test_simultaneous();
    test_alarm();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
